alu_issue_ctrl: RTL and testbench

Sequential front-end for the 16-bit combinational ALU. It accepts operation commands over a valid/ready handshake and holds an 8×16 register file. For each command it drives the ALU operand and select inputs, captures the ALU result and flags, writes the destination register, and returns a response over a second valid/ready handshake. It is the initiator side of the ALU's A/B/Sel → Out/cFlag/zFlag interface and sits between the instruction decode stage and the ALU.

---
 rtl/alu_issue_ctrl_if.sv | 48 ++++
 rtl/alu_issue_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Command and response handshake bundle between the decode stage and
//   the ALU issue controller.
//
//   Parameters
//     DW : datapath width
//     RA : register address width
//
//   Signals
//     cmd_valid / cmd_ready : command handshake
//     cmd_op                : 4-bit opcode
//     cmd_rd/ra/rb          : destination and operand register addresses
//     cmd_imm               : immediate for LDI
//     rsp_valid / rsp_ready : response handshake
//     rsp_data/c/z/err      : response payload
//
//   Modports
//     master : the decode side (issues commands, consumes responses)
//     slave  : the controller side
interface alu_issue_ctrl_if #(
  parameter int DW = 16,
  parameter int RA = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [RA-1:0] cmd_rd;
  logic [RA-1:0] cmd_ra;
  logic [RA-1:0] cmd_rb;
  logic [DW-1:0] cmd_imm;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_c;
  logic          rsp_z;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_c, rsp_z, rsp_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Sequential front-end for the combinational ALU. Accepts commands,
//   reads operands from an internal 2^RA x DW register file, drives the
//   ALU operand/select inputs, captures result and flags, writes the
//   destination register and returns a response.
//
//   Ports
//     clk, rst_n        : clock (rising edge), async active-low reset
//     bus (slave)       : command / response handshakes (alu_issue_ctrl_if)
//     alu_a, alu_b      : registered ALU operands
//     alu_sel           : registered ALU select
//     alu_out           : ALU result
//     alu_c, alu_z      : ALU carry / zero flags
//     op_count          : completed-response counter (ALU_ISSUE_CNT_EN only)
//
//   Configuration
//     ALU_ISSUE_CNT_EN  : when defined, adds the 16-bit op_count output.
//
//   Opcodes: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT,
//            8 SHL, 15 LDI, 9..14 illegal.
module alu_issue_ctrl #(
  parameter int DW = 16,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_ctrl_if.slave bus,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_c,
  input  logic          alu_z
`ifdef ALU_ISSUE_CNT_EN
  ,
  output logic [15:0]   op_count
`endif
);

  localparam logic [3:0] OP_LAST_ALU = 4'd8;
  localparam logic [3:0] OP_LDI      = 4'd15;
  localparam int         NREG        = 1 << RA;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } state_t;

  state_t state;
  state_t next_state;

  logic [DW-1:0] regs [NREG];
  logic [3:0]    op_q;
  logic [RA-1:0] rd_q;
  logic [DW-1:0] imm_q;

  logic [DW-1:0] rsp_data_q;
  logic          rsp_c_q;
  logic          rsp_z_q;
  logic          rsp_err_q;

  logic          cmd_ready_c;
  logic          rsp_valid_c;
  logic          accept;
  logic          cmd_is_alu;
  logic          cmd_is_ldi;
  logic          rsp_done;

  assign cmd_is_alu = (bus.cmd_op <= OP_LAST_ALU);
  assign cmd_is_ldi = (bus.cmd_op == OP_LDI);
  assign accept     = cmd_ready_c && bus.cmd_valid;
  assign rsp_done   = rsp_valid_c && bus.rsp_ready;

  // State register. Reset aborts whatever operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. LDI skips ISSUE because the ALU is not used, and an
  // illegal opcode goes straight to the response with the error flag set.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (cmd_is_alu) begin
            next_state = ISSUE;
          end else if (cmd_is_ldi) begin
            next_state = CAPT;
          end else begin
            next_state = RESP;
          end
        end
      end
      ISSUE:   next_state = CAPT;
      CAPT:    next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs depend only on the current state.
  always_comb begin
    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    case (state)
      IDLE:    cmd_ready_c = 1'b1;
      RESP:    rsp_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_err   = rsp_err_q;

  // Datapath: operands are read from the register file at accept time so
  // that a destination equal to a source register is safe; the write lands
  // only at the end of CAPT. ALU inputs change only on an accepted ALU op
  // and therefore hold their last issued values otherwise. Response fields
  // change only on accept (illegal op) or capture, so they stay stable for
  // the whole RESP state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_data_q <= '0;
      rsp_c_q    <= 1'b0;
      rsp_z_q    <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.cmd_op;
        rd_q <= bus.cmd_rd;
        if (cmd_is_alu) begin
          alu_a   <= regs[bus.cmd_ra];
          alu_b   <= regs[bus.cmd_rb];
          alu_sel <= bus.cmd_op;
        end else if (cmd_is_ldi) begin
          imm_q <= bus.cmd_imm;
        end else begin
          rsp_data_q <= '0;
          rsp_c_q    <= 1'b0;
          rsp_z_q    <= 1'b0;
          rsp_err_q  <= 1'b1;
        end
      end

      if (state == CAPT) begin
        rsp_err_q <= 1'b0;
        if (op_q == OP_LDI) begin
          regs[rd_q] <= imm_q;
          rsp_data_q <= imm_q;
          rsp_c_q    <= 1'b0;
          rsp_z_q    <= (imm_q == '0);
        end else begin
          regs[rd_q] <= alu_out;
          rsp_data_q <= alu_out;
          rsp_c_q    <= alu_c;
          rsp_z_q    <= alu_z;
        end
      end
    end
  end

`ifdef ALU_ISSUE_CNT_EN
  // Counts every completed response handshake, error responses included,
  // wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_done) begin
      op_count <= op_count + 16'd1;
    end
  end
`else
  logic unused_rsp_done;
  assign unused_rsp_done = rsp_done;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Self-checking bench for alu_issue_ctrl. A behavioural ALU stub answers
//   the controller's operands; a reference model (register array plus
//   last-issued operand tracking) predicts responses for random commands.
//   Also exercises op_count when ALU_ISSUE_CNT_EN is defined.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        alu_c;
  logic        alu_z;
`ifdef ALU_ISSUE_CNT_EN
  logic [15:0] op_count;
`endif

  int errors = 0;
  int checks = 0;

  alu_issue_ctrl_if #(.DW(16), .RA(3)) bus ();

  alu_issue_ctrl #(.DW(16), .RA(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_out (alu_out),
    .alu_c   (alu_c),
    .alu_z   (alu_z)
`ifdef ALU_ISSUE_CNT_EN
    ,
    .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {carry, result}. SUB carry is the no-borrow
  // carry of a + ~b + 1; DEC carry is the carry of a + 0xFFFF.
  function automatic logic [16:0] aluRef(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
    case (sel)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} + {1'b0, ~b} + 17'd1;
      4'd2:    return {1'b0, a} + 17'd1;
      4'd3:    return {1'b0, a} + 17'h0FFFF;
      4'd4:    return {1'b0, a & b};
      4'd5:    return {1'b0, a | b};
      4'd6:    return {1'b0, a ^ b};
      4'd7:    return {1'b0, ~a};
      4'd8:    return {a, 1'b0};
      default: return 17'd0;
    endcase
  endfunction

  // Combinational ALU stub connected to the controller.
  always_comb begin
    logic [16:0] r;
    r       = aluRef(alu_sel, alu_a, alu_b);
    alu_out = r[15:0];
    alu_c   = r[16];
    alu_z   = (r[15:0] == 16'd0);
  end

  // Reference model state.
  logic [15:0] mReg [8];
  logic [15:0] lastA;
  logic [15:0] lastB;
  logic [3:0]  lastSel;
  logic [15:0] cntModel;

  task automatic resetModel();
    for (int i = 0; i < 8; i++) mReg[i] = 16'd0;
    lastA    = 16'd0;
    lastB    = 16'd0;
    lastSel  = 4'd0;
    cntModel = 16'd0;
  endtask

  function automatic void modelPredict(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                                       input logic [15:0] imm, output logic [15:0] d, output logic c,
                                       output logic z, output logic e);
    logic [16:0] r;
    d = 16'd0; c = 1'b0; z = 1'b0; e = 1'b0;
    if (op <= 4'd8) begin
      r = aluRef(op, mReg[ra], mReg[rb]);
      d = r[15:0];
      c = r[16];
      z = (r[15:0] == 16'd0);
    end else if (op == 4'd15) begin
      d = imm;
      z = (imm == 16'd0);
    end else begin
      e = 1'b1;
    end
  endfunction

  task automatic modelCommit(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                             input logic [2:0] rb, input logic [15:0] imm);
    logic [16:0] r;
    if (op <= 4'd8) begin
      r       = aluRef(op, mReg[ra], mReg[rb]);
      lastA   = mReg[ra];
      lastB   = mReg[rb];
      lastSel = op;
      mReg[rd] = r[15:0];
    end else if (op == 4'd15) begin
      mReg[rd] = imm;
    end
    cntModel = cntModel + 16'd1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Packs {rsp_valid, cmd_ready, rsp_err, rsp_c, rsp_z, rsp_data}.
  function automatic logic [31:0] rspPack();
    return 32'({bus.rsp_valid, bus.cmd_ready, bus.rsp_err, bus.rsp_c, bus.rsp_z, bus.rsp_data});
  endfunction

  // Issues one command, checks accept-to-response latency (illegal 0, LDI 1,
  // ALU 2 edges after the accept edge), holds rsp_ready low for 'hold'
  // cycles while checking the response stays put, then completes it.
  task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                               input logic [2:0] rb, input logic [15:0] imm, input int hold,
                               input logic [15:0] expData, input logic expC, input logic expZ,
                               input logic expErr, input string tag);
    int lat;
    int expLat;
    int guard;
    logic [31:0] expRsp;
    expLat = expErr ? 0 : ((op == 4'd15) ? 1 : 2);
    expRsp = 32'({1'b1, 1'b0, expErr, expC, expZ, expData});
    guard  = 0;
    @(negedge clk);
    while (!bus.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_imm   = imm;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'($urandom);
    bus.cmd_rd    = 3'($urandom);
    bus.cmd_ra    = 3'($urandom);
    bus.cmd_rb    = 3'($urandom);
    bus.cmd_imm   = 16'($urandom);
    lat = 0;
    while (!bus.rsp_valid && lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
    for (int i = 0; i < hold; i++) begin
      checkOutput({tag, " rsp hold"}, rspPack(), expRsp);
      @(posedge clk);
      #1;
    end
    checkOutput({tag, " rsp"}, rspPack(), expRsp);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    modelCommit(op, rd, ra, rb, imm);
    checkOutput({tag, " post ready/valid"}, 32'({bus.cmd_ready, bus.rsp_valid}), 32'b10);
    checkOutput({tag, " alu_ab"}, {alu_a, alu_b}, {lastA, lastB});
    checkOutput({tag, " alu_sel"}, 32'(alu_sel), 32'(lastSel));
`ifdef ALU_ISSUE_CNT_EN
    checkOutput({tag, " op_count"}, 32'(op_count), 32'(cntModel));
`endif
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " rsp/ready"}, rspPack(), 32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}));
    checkOutput({tag, " alu_ab"}, {alu_a, alu_b}, 32'd0);
    checkOutput({tag, " alu_sel"}, 32'(alu_sel), 32'd0);
`ifdef ALU_ISSUE_CNT_EN
    checkOutput({tag, " op_count"}, 32'(op_count), 32'd0);
`endif
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] imm;
    int          hold;
    logic [15:0] expData;
    logic        expC;
    logic        expZ;
    logic        expErr;
  } vec_t;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl [15];
    logic [15:0] d;
    logic c, z, e;
    logic [3:0] op;
    int r;

    // Hand-derived expectations starting from an all-zero register file.
    tbl[0]  = '{4'd15, 3'd1, 3'd0, 3'd0, 16'h0001, 0, 16'h0001, 1'b0, 1'b0, 1'b0}; // LDI r1=1
    tbl[1]  = '{4'd15, 3'd2, 3'd0, 3'd0, 16'h0002, 1, 16'h0002, 1'b0, 1'b0, 1'b0}; // LDI r2=2
    tbl[2]  = '{4'd0,  3'd3, 3'd1, 3'd2, 16'h0000, 0, 16'h0003, 1'b0, 1'b0, 1'b0}; // ADD r3=r1+r2
    tbl[3]  = '{4'd1,  3'd4, 3'd1, 3'd2, 16'h0000, 0, 16'hFFFF, 1'b0, 1'b0, 1'b0}; // SUB r4=r1-r2
    tbl[4]  = '{4'd4,  3'd5, 3'd1, 3'd2, 16'h0000, 2, 16'h0000, 1'b0, 1'b1, 1'b0}; // AND r5=r1&r2
    tbl[5]  = '{4'd15, 3'd6, 3'd0, 3'd0, 16'hFFFF, 0, 16'hFFFF, 1'b0, 1'b0, 1'b0}; // LDI r6=FFFF
    tbl[6]  = '{4'd2,  3'd6, 3'd6, 3'd0, 16'h0000, 0, 16'h0000, 1'b1, 1'b1, 1'b0}; // INC r6
    tbl[7]  = '{4'd0,  3'd7, 3'd6, 3'd1, 16'h0000, 0, 16'h0001, 1'b0, 1'b0, 1'b0}; // ADD r7=r6+r1
    tbl[8]  = '{4'd10, 3'd1, 3'd1, 3'd1, 16'h1234, 3, 16'h0000, 1'b0, 1'b0, 1'b1}; // illegal
    tbl[9]  = '{4'd15, 3'd0, 3'd0, 3'd0, 16'h0000, 0, 16'h0000, 1'b0, 1'b1, 1'b0}; // LDI r0=0
    tbl[10] = '{4'd8,  3'd3, 3'd4, 3'd0, 16'h0000, 1, 16'hFFFE, 1'b1, 1'b0, 1'b0}; // SHL r3=r4<<1
    tbl[11] = '{4'd6,  3'd3, 3'd3, 3'd3, 16'h0000, 0, 16'h0000, 1'b0, 1'b1, 1'b0}; // XOR r3=r3^r3
    tbl[12] = '{4'd3,  3'd5, 3'd5, 3'd0, 16'h0000, 0, 16'hFFFF, 1'b0, 1'b0, 1'b0}; // DEC r5 (0)
    tbl[13] = '{4'd7,  3'd2, 3'd2, 3'd0, 16'h0000, 0, 16'hFFFD, 1'b0, 1'b0, 1'b0}; // NOT r2
    tbl[14] = '{4'd5,  3'd1, 3'd1, 3'd2, 16'h0000, 0, 16'hFFFD, 1'b0, 1'b0, 1'b0}; // OR r1=r1|r2

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'd0;
    bus.cmd_rd    = 3'd0;
    bus.cmd_ra    = 3'd0;
    bus.cmd_rb    = 3'd0;
    bus.cmd_imm   = 16'd0;
    bus.rsp_ready = 1'b0;
    resetModel();

    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].op, tbl[i].rd, tbl[i].ra, tbl[i].rb, tbl[i].imm, tbl[i].hold,
                    tbl[i].expData, tbl[i].expC, tbl[i].expZ, tbl[i].expErr, $sformatf("vec%0d", i));
    end

    // Reset asserted during the ISSUE cycle of ADD r1 = r1 + r2.
    @(negedge clk);
    checkOutput("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 4'd0;
    bus.cmd_rd    = 3'd1;
    bus.cmd_ra    = 3'd1;
    bus.cmd_rb    = 3'd2;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    resetModel();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort no rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    checkResetState("abort reset");
    rst_n = 1'b1;
    applyStimulus(4'd0, 3'd0, 3'd1, 3'd2, 16'h0, 0, 16'h0000, 1'b0, 1'b1, 1'b0, "post-abort ADD");

    // Four more commands, one illegal: five handshakes since the reset.
    applyStimulus(4'd15, 3'd1, 3'd0, 3'd0, 16'h0007, 0, 16'h0007, 1'b0, 1'b0, 1'b0, "cnt LDI");
    applyStimulus(4'd12, 3'd1, 3'd0, 3'd0, 16'h0000, 1, 16'h0000, 1'b0, 1'b0, 1'b1, "cnt illegal");
    applyStimulus(4'd0,  3'd2, 3'd1, 3'd1, 16'h0000, 0, 16'h000E, 1'b0, 1'b0, 1'b0, "cnt ADD");
    applyStimulus(4'd1,  3'd3, 3'd2, 3'd1, 16'h0000, 0, 16'h0007, 1'b1, 1'b0, 1'b0, "cnt SUB");
`ifdef ALU_ISSUE_CNT_EN
    checkOutput("op_count five", 32'(op_count), 32'd5);
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    cntModel = 16'hFFFF;
    checkOutput("op_count preload", 32'(op_count), 32'hFFFF);
    applyStimulus(4'd15, 3'd4, 3'd0, 3'd0, 16'h00A5, 0, 16'h00A5, 1'b0, 1'b0, 1'b0, "cnt wrap");
    checkOutput("op_count wrap", 32'(op_count), 32'd0);
`endif

    // Random commands checked against the reference model.
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 11));
      if (r <= 8)       op = 4'(r);
      else if (r == 9)  op = 4'd15;
      else              op = 4'($urandom_range(9, 14));
      begin
        logic [2:0]  rd, ra, rb;
        logic [15:0] imm;
        rd  = 3'($urandom);
        ra  = 3'($urandom);
        rb  = 3'($urandom);
        case ($urandom_range(0, 3))
          0:       imm = 16'h0000;
          1:       imm = 16'hFFFF;
          default: imm = 16'($urandom);
        endcase
        modelPredict(op, ra, rb, imm, d, c, z, e);
        applyStimulus(op, rd, ra, rb, imm, int'($urandom_range(0, 2)), d, c, z, e,
                      $sformatf("rand%0d op%0d", k, op));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
